bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the consecutive-equal-bit detector FSM: accepts
//  DATA_W-bit words over a valid/ready handshake and drives them one bit per bit period,
//  MSB first, onto dout_bit, which connects to the detector's din_bit. Provides bit-period
//  pacing, framing strobes and gapless back-to-back frames.
// PARAMETERS
//  DATA_W   8   word width; legal range 2..32
//  DIV      1   clocks per bit period; >=1; divider width = max(1,$clog2(DIV))
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  reset      in   1        asynchronous, active-high; clears all state immediately
//  in_data    in   DATA_W   parallel word to serialize
//  in_valid   in   1        in_data valid
//  in_ready   out  1        block can accept a word this cycle
//  dout_bit   out  1        serial data bit (to detector din_bit)
//  bit_valid  out  1        high while dout_bit carries a data (or parity) bit
//  bit_tick   out  1        1-cycle pulse on the last clock of each bit period
//  frame_done out  1        1-cycle pulse on the last clock of the frame's final bit
//  busy       out  1        high in any state except IDLE
// BEHAVIOUR
//  - Reset values: state=IDLE, in_ready=1, dout_bit=0, bit_valid=0, bit_tick=0,
//    frame_done=0, busy=0, divider=0, bit counter=0. Reset mid-frame aborts the frame; partial bits are discarded.
//  - States: IDLE -> SHIFT [-> PARITY] -> IDLE or SHIFT (back-to-back).
//  - Accept = in_valid & in_ready. On accept: shift reg <= in_data, bit_cnt <= 0, div <= 0,
//    state <= SHIFT. First bit (in_data[DATA_W-1]) appears on dout_bit the next cycle.
//  - SHIFT: dout_bit = shreg[DATA_W-1]; bit_valid=1. div counts 0..DIV-1; at div==DIV-1
//    bit_tick=1, div<=0, shreg shifts left (0 in), bit_cnt++. After DATA_W ticks the frame ends.
//  - in_ready = (state==IDLE) | (last clock of the frame's final bit). If accept occurs
//    on that last clock, next word starts in SHIFT with no idle gap; else -> IDLE.
//  - in_data is sampled only on accept; changes while busy are ignored.
//  - frame_done asserts together with the final bit_tick of the frame.
//  - IDLE: dout_bit=0, bit_valid=0, bit_tick=0.
//  - Latency: accept at cycle N -> first bit valid cycle N+1; frame occupies
//    DATA_W*DIV cycles (plus DIV with parity).
//  - Outputs dout_bit, bit_valid, busy are registered-state decodes (no in_valid path);
//    in_ready is combinational from state/div/bit_cnt only.
// CONFIGURATION
//  SER_PARITY_EN defined: after the DATA_W data bits, state PARITY drives one extra bit
//    period carrying even parity (XOR of the accepted word); bit_valid=1, bit_tick fires,
//    frame_done and the back-to-back in_ready window move to the parity bit's last clock.
//  SER_PARITY_EN undefined: no PARITY state; frame is exactly DATA_W bit periods.
// TESTING
//  1 Reset: assert reset mid-frame (bit 3 of 8) -> same cycle dout_bit=0, bit_valid=0,
//    busy=0, in_ready=1; after release next accept starts cleanly from MSB.
//  2 DIV=1, in_data=8'hB4, single accept -> dout_bit 1,0,1,1,0,1,0,0 on 8 consecutive
//    cycles, bit_tick every cycle, frame_done on 8th, in_ready high on 8th and after.
//  3 DIV=4, in_data=8'h81 -> each bit held 4 cycles, bit_tick on every 4th, frame 32 cycles.
//  4 Back-to-back DIV=1: in_valid held high with 8'hF0 then 8'h0F -> 16 contiguous bits,
//    bit_valid never drops; detector downstream outputs 1 on the repeated-bit positions.
//  5 in_valid high while busy with changing in_data -> no accept until in_ready; sent
//    word equals the value present on the accept cycle.
//  6 SER_PARITY_EN, in_data=8'h07 -> 9 bits, 9th bit=1; 8'h03 -> 9th bit=0.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The slave modport is the serializer; the master modport is whoever feeds it words.
interface bit_serializer_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              dout_bit;
    logic              bit_valid;
    logic              bit_tick;
    logic              frame_done;
    logic              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, dout_bit, bit_valid, bit_tick, frame_done, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dout_bit, bit_valid, bit_tick, frame_done, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: MSB-first, DIV clocks per bit, gapless back-to-back frames.
// Define SER_PARITY_EN to append one even-parity bit period after the data bits.
module bit_serializer #(
    parameter int DATA_W = 8,
    parameter int DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    bit_serializer_if.slave   bus
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
`ifdef SER_PARITY_EN
    logic              par_q,   par_d;
`endif

    logic tick, frame_end, ready, accept;

    // Bit-period and framing decodes depend only on registered state, never on in_valid.
    always_comb begin
        tick = (state_q != S_IDLE) && (div_q == DIV_LAST);
`ifdef SER_PARITY_EN
        frame_end = tick && (state_q == S_PARITY);
`else
        frame_end = tick && (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
`endif
        ready  = (state_q == S_IDLE) || frame_end;
        accept = bus.in_valid && ready;
    end

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_SHIFT: begin
                if (tick) begin
                    div_d   = '0;
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
`ifdef SER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_IDLE;
`endif
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`endif
            S_IDLE:  ;
            default: state_d = S_IDLE;
        endcase

        // A word accepted on the frame's last clock overrides the return to IDLE.
        if (accept) begin
            state_d = S_SHIFT;
            shreg_d = bus.in_data;
            div_d   = '0;
            cnt_d   = '0;
`ifdef SER_PARITY_EN
            par_d   = ^bus.in_data;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        bus.dout_bit  = 1'b0;
        bus.bit_valid = 1'b0;
        case (state_q)
            S_SHIFT: begin
                bus.dout_bit  = shreg_q[DATA_W-1];
                bus.bit_valid = 1'b1;
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                bus.dout_bit  = par_q;
                bus.bit_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.in_ready   = ready;
    assign bus.bit_tick   = tick;
    assign bus.frame_done = frame_end;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: DIV=1 and DIV=4 instances, expected bits queued at accept.
// Build with +define+SER_PARITY_EN to exercise the parity bit.
module tb_bit_serializer;
    localparam int W  = 8;
    localparam int D1 = 1;
    localparam int D4 = 4;
`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB = W + PB;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bit_serializer_if #(.DATA_W(W)) b1 ();
    bit_serializer_if #(.DATA_W(W)) b4 ();

    bit_serializer #(.DATA_W(W), .DIV(D1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    bit_serializer #(.DATA_W(W), .DIV(D4)) dut4 (.clk(clk), .reset(reset), .bus(b4));

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ph1   = 0;
    int   ph4   = 0;
    logic et1, et4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Expected serial stream for one accepted word: MSB first, then parity when enabled.
    task automatic push(input int which, input logic [W-1:0] w);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b    = w[i];
            e.last = (i == 0) && (PB == 0);
            if (which == 1) q1.push_back(e); else q4.push_back(e);
        end
        if (PB == 1) begin
            e.b    = ^w;
            e.last = 1'b1;
            if (which == 1) q1.push_back(e); else q4.push_back(e);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [W-1:0] d);
        if (which == 1) begin b1.in_valid = v; b1.in_data = d; end
        else            begin b4.in_valid = v; b4.in_data = d; end
    endtask

    function automatic logic rdy(input int which);
        return (which == 1) ? b1.in_ready : b4.in_ready;
    endfunction

    function automatic logic bsy(input int which);
        return (which == 1) ? b1.busy : b4.busy;
    endfunction

    // Called just after a negedge. Holds in_valid until in_ready is seen; chg scrambles in_data while waiting.
    task automatic send(input int which, input logic [W-1:0] w, input bit hold, input bit chg);
        logic [W-1:0] d;
        bit done;
        d    = w;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            drive(which, 1'b1, d);
            if (rdy(which)) begin
                push(which, d);
                done = 1'b1;
                @(negedge clk);
                if (!hold) drive(which, 1'b0, d);
            end else begin
                if (chg) begin
                    check("busy_while_waiting", {31'd0, bsy(which)}, 32'd1);
                    d = d + 8'h37;
                end
                @(negedge clk);
            end
        end
        if (!done) timeout("send");
    endtask

    task automatic wait_idle(input int which);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (!bsy(which)) done = 1'b1;
        end
        if (!done) timeout("wait_idle");
    endtask

    // Monitors: compare dout_bit every valid cycle, pop on each bit_tick, and police tick spacing.
    always @(negedge clk) begin
        if (reset) begin
            ph1 = 0;
        end else if (b1.bit_valid) begin
            et1 = (ph1 == D1 - 1);
            check("tick1", {31'd0, b1.bit_tick}, {31'd0, et1});
            check("q1_has_entry", {31'd0, q1.size() > 0}, 32'd1);
            if (q1.size() > 0) begin
                check("dout1", {31'd0, b1.dout_bit}, {31'd0, q1[0].b});
                check("frame_done1", {31'd0, b1.frame_done}, {31'd0, et1 & q1[0].last});
                if (et1 && q1[0].last) check("ready_last1", {31'd0, b1.in_ready}, 32'd1);
                if (et1) void'(q1.pop_front());
            end
            ph1 = et1 ? 0 : ph1 + 1;
        end else begin
            ph1 = 0;
            check("tick_idle1", {31'd0, b1.bit_tick}, 32'd0);
            check("ready_idle1", {31'd0, b1.in_ready}, 32'd1);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            ph4 = 0;
        end else if (b4.bit_valid) begin
            et4 = (ph4 == D4 - 1);
            check("tick4", {31'd0, b4.bit_tick}, {31'd0, et4});
            check("q4_has_entry", {31'd0, q4.size() > 0}, 32'd1);
            if (q4.size() > 0) begin
                check("dout4", {31'd0, b4.dout_bit}, {31'd0, q4[0].b});
                check("frame_done4", {31'd0, b4.frame_done}, {31'd0, et4 & q4[0].last});
                if (et4 && q4[0].last) check("ready_last4", {31'd0, b4.in_ready}, 32'd1);
                if (et4) void'(q4.pop_front());
            end
            ph4 = et4 ? 0 : ph4 + 1;
        end else begin
            ph4 = 0;
            check("tick_idle4", {31'd0, b4.bit_tick}, 32'd0);
            check("ready_idle4", {31'd0, b4.in_ready}, 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dn;
        drive(1, 1'b0, '0);
        drive(4, 1'b0, '0);

        // Reset state of both instances.
        #12;
        check("rst_ready1", {31'd0, b1.in_ready}, 32'd1);
        check("rst_busy1",  {31'd0, b1.busy},     32'd0);
        check("rst_valid1", {31'd0, b1.bit_valid}, 32'd0);
        check("rst_dout1",  {31'd0, b1.dout_bit},  32'd0);
        check("rst_tick1",  {31'd0, b1.bit_tick},  32'd0);
        check("rst_done1",  {31'd0, b1.frame_done}, 32'd0);
        check("rst_ready4", {31'd0, b4.in_ready}, 32'd1);
        check("rst_busy4",  {31'd0, b4.busy},     32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset mid-frame: abort while bit 3 of 8'hA5 is on the line.
        send(1, 8'hA5, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_dout",  {31'd0, b1.dout_bit},  32'd0);
        check("midrst_valid", {31'd0, b1.bit_valid}, 32'd0);
        check("midrst_busy",  {31'd0, b1.busy},      32'd0);
        check("midrst_ready", {31'd0, b1.in_ready},  32'd1);
        q1.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        send(1, 8'h5A, 1'b0, 1'b0);
        wait_idle(1);

        // DIV=1 single word.
        send(1, 8'hB4, 1'b0, 1'b0);
        wait_idle(1);

        // DIV=4: frame length measured from first data cycle to frame_done.
        send(4, 8'h81, 1'b0, 1'b0);
        cyc = 1;
        for (int t = 0; t < 200 && !b4.frame_done; t++) begin
            @(negedge clk);
            cyc++;
        end
        check("frame_len4", cyc, NB * D4);
        wait_idle(4);

        // Back-to-back: two frames must occupy exactly 2*NB contiguous cycles.
        dn  = 0;
        cyc = 0;
        fork
            begin
                send(1, 8'hF0, 1'b1, 1'b0);
                send(1, 8'h0F, 1'b0, 1'b0);
            end
            begin
                for (int t = 0; t < 100 && dn < 2; t++) begin
                    @(negedge clk);
                    cyc++;
                    if (b1.frame_done) dn++;
                end
            end
        join
        check("b2b_frames", dn, 2);
        check("b2b_len", cyc, 2 * NB);
        wait_idle(1);

        // in_data changes while busy; only the value on the accept cycle is sent.
        send(1, 8'h3C, 1'b0, 1'b0);
        send(1, 8'h11, 1'b0, 1'b1);
        wait_idle(1);

        // Parity-relevant words (odd and even population), plus a DIV=4 pattern.
        send(1, 8'h07, 1'b0, 1'b0);
        wait_idle(1);
        send(1, 8'h03, 1'b0, 1'b0);
        send(4, 8'hA5, 1'b0, 1'b0);
        wait_idle(1);
        wait_idle(4);

        repeat (2) @(negedge clk);
        check("q1_drained", q1.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
